// File: rtl/msu_sd_sector_responder.sv
// Responder for the MSU audio sector-read handshake: streams one sector of words from a fixed-latency word memory.
// Optional build macro MSU_SD_TAIL_ZERO_EN zero-fills words that lie at or beyond the latched image size.
module msu_sd_sector_responder #(
  parameter int unsigned SECTOR_WORDS = 256,
  parameter int unsigned LBA_W        = 21,
  parameter int unsigned MEM_LATENCY  = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sd_rd,
  input  logic [LBA_W-1:0]   sd_lba,
  input  logic [31:0]        img_size,
  output logic               sd_ack,
  output logic               sd_buff_wr,
  output logic [7:0]         sd_buff_addr,
  output logic [15:0]        sd_buff_dout,
  output logic               mem_rd,
  output logic [LBA_W+7:0]   mem_addr,
  input  logic [15:0]        mem_rdata,
  output logic               busy,
  output logic [15:0]        sectors_served
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT, S_WRITE, S_DONE, S_RELEASE
  } state_t;

  localparam logic [7:0] LAST_IDX = 8'(SECTOR_WORDS - 1);
  localparam logic [2:0] LAT      = 3'(MEM_LATENCY);

  state_t           state;
  logic [LBA_W-1:0] lba_q;
  logic [31:0]      img_size_q;
  logic [7:0]       idx;
  logic [7:0]       idx_next;
  logic [2:0]       lat_cnt;
  logic             tail_q;
  logic             accept_tail;
  logic             step_tail;

  assign idx_next = idx + 8'd1;
  assign busy     = (state != S_IDLE);

  // Tail decision is made one cycle early so mem_rd can be a registered strobe in FETCH.
`ifdef MSU_SD_TAIL_ZERO_EN
  always_comb begin
    accept_tail = 1'b0;
    step_tail   = 1'b0;
    accept_tail = (32'(sd_lba) << 9) >= img_size;
    step_tail   = ((32'(lba_q) << 9) + 32'({idx_next, 1'b0})) >= img_size_q;
  end
`else
  logic unused_img;
  assign unused_img  = ^img_size_q;
  assign accept_tail = 1'b0;
  assign step_tail   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_IDLE;
      lba_q          <= '0;
      img_size_q     <= '0;
      idx            <= '0;
      lat_cnt        <= '0;
      tail_q         <= 1'b0;
      sd_ack         <= 1'b0;
      sd_buff_wr     <= 1'b0;
      sd_buff_addr   <= '0;
      sd_buff_dout   <= '0;
      mem_rd         <= 1'b0;
      mem_addr       <= '0;
      sectors_served <= '0;
    end else begin
      mem_rd     <= 1'b0;
      sd_buff_wr <= 1'b0;
      case (state)
        S_IDLE: begin
          if (sd_rd) begin
            lba_q      <= sd_lba;
            img_size_q <= img_size;
            idx        <= '0;
            sd_ack     <= 1'b1;
            mem_addr   <= {sd_lba, 8'h00};
            tail_q     <= accept_tail;
            mem_rd     <= !accept_tail;
            state      <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (tail_q) begin
            sd_buff_wr   <= 1'b1;
            sd_buff_addr <= idx;
            sd_buff_dout <= '0;
            state        <= S_WRITE;
          end else begin
            lat_cnt <= 3'd1;
            state   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (lat_cnt == LAT) begin
            lat_cnt      <= '0;
            sd_buff_wr   <= 1'b1;
            sd_buff_addr <= idx;
            sd_buff_dout <= mem_rdata;
            state        <= S_WRITE;
          end else begin
            lat_cnt <= lat_cnt + 3'd1;
          end
        end
        S_WRITE: begin
          if (idx == LAST_IDX) begin
            sd_ack         <= 1'b0;
            sectors_served <= sectors_served + 16'd1;
            state          <= S_DONE;
          end else begin
            idx      <= idx_next;
            mem_addr <= {lba_q, idx_next};
            tail_q   <= step_tail;
            mem_rd   <= !step_tail;
            state    <= S_FETCH;
          end
        end
        S_DONE: state <= S_RELEASE;
        S_RELEASE: begin
          if (!sd_rd) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_msu_sd_sector_responder.sv
// Bench for msu_sd_sector_responder: two instances (default and MEM_LATENCY=1/SECTOR_WORDS=64) against a cycle-schedule model.
`timescale 1ns/1ps
module tb_msu_sd_sector_responder;
  localparam int KEYM = 1 << 20;
`ifdef MSU_SD_TAIL_ZERO_EN
  localparam bit TAIL_EN = 1'b1;
`else
  localparam bit TAIL_EN = 1'b0;
`endif

  logic clk, reset;
  logic [1:0]        rd_v, ack_v, wr_v, mrd_v, busy_v;
  logic [1:0][20:0]  lba_v;
  logic [1:0][31:0]  size_v;
  logic [1:0][7:0]   baddr_v;
  logic [1:0][15:0]  dout_v, rdata_v, srv_v;
  logic [1:0][28:0]  maddr_v;

  msu_sd_sector_responder #(.SECTOR_WORDS(256), .LBA_W(21), .MEM_LATENCY(2)) dut0 (
    .clk(clk), .reset(reset), .sd_rd(rd_v[0]), .sd_lba(lba_v[0]), .img_size(size_v[0]),
    .sd_ack(ack_v[0]), .sd_buff_wr(wr_v[0]), .sd_buff_addr(baddr_v[0]), .sd_buff_dout(dout_v[0]),
    .mem_rd(mrd_v[0]), .mem_addr(maddr_v[0]), .mem_rdata(rdata_v[0]), .busy(busy_v[0]),
    .sectors_served(srv_v[0]));

  msu_sd_sector_responder #(.SECTOR_WORDS(64), .LBA_W(21), .MEM_LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .sd_rd(rd_v[1]), .sd_lba(lba_v[1]), .img_size(size_v[1]),
    .sd_ack(ack_v[1]), .sd_buff_wr(wr_v[1]), .sd_buff_addr(baddr_v[1]), .sd_buff_dout(dout_v[1]),
    .mem_rd(mrd_v[1]), .mem_addr(maddr_v[1]), .mem_rdata(rdata_v[1]), .busy(busy_v[1]),
    .sectors_served(srv_v[1]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory image: word at address A holds A[15:0]; data only present exactly at the latency slot.
  logic [15:0] p0a, p0b, p1a;
  logic        v0a, v0b, v1a;
  always @(posedge clk) begin
    v0a <= mrd_v[0]; p0a <= maddr_v[0][15:0];
    v0b <= v0a;      p0b <= p0a;
    v1a <= mrd_v[1]; p1a <= maddr_v[1][15:0];
  end
  assign rdata_v[0] = (v0b === 1'b1) ? p0b : 16'hDEAD;
  assign rdata_v[1] = (v1a === 1'b1) ? p1a : 16'hDEAD;

  int n_chk = 0, n_pass = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
  endtask

  // Model: per-cycle event tables keyed by instance*KEYM + cycle.
  logic [31:0] wr_ev[int];
  logic [31:0] rd_ev[int];
  logic [31:0] ack_chg[int];
  logic [31:0] srv_chg[int];
  int          srv_cnt[2];
  logic        cur_ack[2];
  logic [15:0] cur_srv[2];
  int          ack_cnt[2], wr_cnt[2], rd_cnt[2];
  logic [15:0] last_dout[2];
  bit          chk_en = 1'b0;

  function automatic int key(input int d, input int c);
    return d * KEYM + c;
  endfunction
  function automatic int lat_of(input int d);
    return (d == 0) ? 2 : 1;
  endfunction
  function automatic int sw_of(input int d);
    return (d == 0) ? 256 : 64;
  endfunction

  // Request sampled at edge p+1; each word costs 2 cycles when zero-filled, latency+2 otherwise.
  task automatic plan(input int d, input int p, input int lba, input logic [31:0] size, output int last_w);
    int f, w, addr;
    logic [31:0] off;
    bit tail;
    f = p + 1;
    w = f;
    ack_chg[key(d, p + 1)] = 32'd1;
    for (int k = 0; k < sw_of(d); k++) begin
      off  = 32'(lba) * 32'd512 + 32'(k) * 32'd2;
      tail = TAIL_EN && (off >= size);
      addr = lba * 256 + k;
      if (!tail) rd_ev[key(d, f)] = 32'(addr);
      w = f + (tail ? 1 : lat_of(d) + 1);
      wr_ev[key(d, w)] = {16'(k), tail ? 16'h0000 : 16'(addr)};
      f = w + 1;
    end
    ack_chg[key(d, w + 1)] = 32'd0;
    srv_cnt[d]++;
    srv_chg[key(d, w + 1)] = 32'(srv_cnt[d]);
    last_w = w;
  endtask

  task automatic model_reset(input int p);
    int ks[$];
    ks.delete(); foreach (wr_ev[k])   if (k % KEYM > p) ks.push_back(k); foreach (ks[i]) wr_ev.delete(ks[i]);
    ks.delete(); foreach (rd_ev[k])   if (k % KEYM > p) ks.push_back(k); foreach (ks[i]) rd_ev.delete(ks[i]);
    ks.delete(); foreach (ack_chg[k]) if (k % KEYM > p) ks.push_back(k); foreach (ks[i]) ack_chg.delete(ks[i]);
    ks.delete(); foreach (srv_chg[k]) if (k % KEYM > p) ks.push_back(k); foreach (ks[i]) srv_chg.delete(ks[i]);
    for (int d = 0; d < 2; d++) begin
      ack_chg[key(d, p + 1)] = 32'd0;
      srv_chg[key(d, p + 1)] = 32'd0;
      srv_cnt[d] = 0;
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        int k;
        bit ew, er;
        k = key(d, cyc);
        if (ack_chg.exists(k)) cur_ack[d] = ack_chg[k][0];
        if (srv_chg.exists(k)) cur_srv[d] = srv_chg[k][15:0];
        ew = wr_ev.exists(k);
        er = rd_ev.exists(k);
        chk($sformatf("d%0d sd_ack", d), 64'(ack_v[d]), 64'(cur_ack[d]));
        chk($sformatf("d%0d sd_buff_wr", d), 64'(wr_v[d]), 64'(ew));
        if (ew) begin
          chk($sformatf("d%0d sd_buff_addr", d), 64'(baddr_v[d]), 64'(wr_ev[k][23:16]));
          chk($sformatf("d%0d sd_buff_dout", d), 64'(dout_v[d]), 64'(wr_ev[k][15:0]));
        end
        chk($sformatf("d%0d mem_rd", d), 64'(mrd_v[d]), 64'(er));
        if (er) chk($sformatf("d%0d mem_addr", d), 64'(maddr_v[d]), 64'(rd_ev[k]));
        chk($sformatf("d%0d sectors_served", d), 64'(srv_v[d]), 64'(cur_srv[d]));
        if (ack_v[d] === 1'b1) ack_cnt[d]++;
        if (mrd_v[d] === 1'b1) rd_cnt[d]++;
        if (wr_v[d] === 1'b1) begin
          wr_cnt[d]++;
          last_dout[d] = dout_v[d];
        end
      end
    end
  end

  task automatic step(input int n);
    if (n > 0) begin
      repeat (n) @(posedge clk);
      #1;
    end
  endtask

  task automatic clr(input int d);
    ack_cnt[d] = 0; wr_cnt[d] = 0; rd_cnt[d] = 0; last_dout[d] = 16'h0;
  endtask

  task automatic start_req(input int d, input int lba, input logic [31:0] size, output int p, output int w);
    clr(d);
    p = cyc;
    rd_v[d] = 1'b1; lba_v[d] = 21'(lba); size_v[d] = size;
    plan(d, p, lba, size, w);
  endtask

  task automatic release_req(input int d);
    rd_v[d] = 1'b0;
    step(3);
  endtask

  int p, w;

  initial begin
    reset = 1'b1; rd_v = '0; lba_v = '0; size_v = '1;
    for (int d = 0; d < 2; d++) begin
      cur_ack[d] = 1'b0; cur_srv[d] = 16'h0; srv_cnt[d] = 0; clr(d);
    end
    step(3);
    reset = 1'b0;
    for (int d = 0; d < 2; d++) begin
      chk("reset sd_ack", 64'(ack_v[d]), 64'd0);
      chk("reset sd_buff_wr", 64'(wr_v[d]), 64'd0);
      chk("reset sd_buff_addr", 64'(baddr_v[d]), 64'd0);
      chk("reset sd_buff_dout", 64'(dout_v[d]), 64'd0);
      chk("reset mem_rd", 64'(mrd_v[d]), 64'd0);
      chk("reset mem_addr", 64'(maddr_v[d]), 64'd0);
      chk("reset busy", 64'(busy_v[d]), 64'd0);
      chk("reset sectors_served", 64'(srv_v[d]), 64'd0);
    end
    chk_en = 1'b1;
    step(2);

    // Sector lba 3, 4-cycle word spacing
    start_req(0, 3, 32'hFFFF_FFFF, p, w);
    chk("t1 model first word", 64'(wr_ev[key(0, p + 4)]), 64'h0000_0300);
    step(2);
    chk("t1 ack one cycle after accept", 64'(ack_v[0]), 64'd1);
    step(w + 1 - cyc);
    chk("t1 strobes", 64'(wr_cnt[0]), 64'd256);
    chk("t1 last dout", 64'(last_dout[0]), 64'h03FF);
    chk("t1 ack cycles", 64'(ack_cnt[0]), 64'd1024);
    chk("t1 served", 64'(srv_v[0]), 64'd1);

    // Held request is not served twice
    step(2000);
    chk("t2 busy in release", 64'(busy_v[0]), 64'd1);
    chk("t2 no extra strobes", 64'(wr_cnt[0]), 64'd256);
    chk("t2 served once", 64'(srv_v[0]), 64'd1);
    release_req(0);
    chk("t2 idle after release", 64'(busy_v[0]), 64'd0);
    start_req(0, 4, 32'hFFFF_FFFF, p, w);
    step(w + 1 - cyc);
    chk("t2 second served", 64'(srv_v[0]), 64'd2);
    chk("t2 second last dout", 64'(last_dout[0]), 64'h04FF);
    release_req(0);

    // sd_rd dropped and lba changed at word 10
    start_req(0, 5, 32'hFFFF_FFFF, p, w);
    step(p + 44 - cyc);
    rd_v[0] = 1'b0; lba_v[0] = 21'd9;
    step(w + 1 - cyc);
    chk("t4 strobes", 64'(wr_cnt[0]), 64'd256);
    chk("t4 last dout", 64'(last_dout[0]), 64'h05FF);
    chk("t4 served", 64'(srv_v[0]), 64'd3);
    step(3);

    // Image ends 100 bytes into sector 4
    start_req(0, 4, 32'd2148, p, w);
    step(w + 1 - cyc);
    chk("t5 strobes", 64'(wr_cnt[0]), 64'd256);
    chk("t5 mem reads", 64'(rd_cnt[0]), TAIL_EN ? 64'd50 : 64'd256);
    chk("t5 last dout", 64'(last_dout[0]), TAIL_EN ? 64'h0000 : 64'h04FF);
    chk("t5 ack cycles", 64'(ack_cnt[0]), TAIL_EN ? 64'd612 : 64'd1024);
    release_req(0);

    // Reset at word 100
    start_req(0, 6, 32'hFFFF_FFFF, p, w);
    step(p + 404 - cyc);
    reset = 1'b1; rd_v[0] = 1'b0;
    model_reset(cyc);
    step(1);
    reset = 1'b0;
    chk("t3 ack after reset", 64'(ack_v[0]), 64'd0);
    chk("t3 wr after reset", 64'(wr_v[0]), 64'd0);
    chk("t3 busy after reset", 64'(busy_v[0]), 64'd0);
    chk("t3 strobes before reset", 64'(wr_cnt[0]), 64'd101);
    step(10);
    start_req(0, 7, 32'hFFFF_FFFF, p, w);
    step(w + 1 - cyc);
    chk("t3 full sector after reset", 64'(wr_cnt[0]), 64'd256);
    chk("t3 served after reset", 64'(srv_v[0]), 64'd1);
    release_req(0);

    // Latency 1, 64-word sectors
    start_req(1, 2, 32'hFFFF_FFFF, p, w);
    step(w + 1 - cyc);
    chk("t6 strobes", 64'(wr_cnt[1]), 64'd64);
    chk("t6 ack cycles", 64'(ack_cnt[1]), 64'd192);
    chk("t6 last dout", 64'(last_dout[1]), 64'h023F);
    chk("t6 served", 64'(srv_v[1]), 64'd1);
    release_req(1);
    step(5);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/msu_sd_sector_responder.md
Name: msu_sd_sector_responder

Overview:
Responder end of the MSU audio sector-read handshake. Accepts a sector request as sd_rd plus sd_lba from the audio requester. Asserts sd_ack for the whole transfer and streams SECTOR_WORDS 16-bit words as sd_buff_wr strobes with sd_buff_addr/sd_buff_dout. Words come from a fixed-latency word memory holding the mounted audio image. Sits between the HPS-side image store (or bench memory model) and the MSU audio sector requester.

Parameters:
SECTOR_WORDS, 256, words per sector; power of two, 2..256.
LBA_W, 21, width of sd_lba.
MEM_LATENCY, 2, cycles from the mem_rd cycle to mem_rdata valid; 1..7.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
sd_rd  in  1  level sector request; held by requester until sd_ack seen
sd_lba  in  LBA_W  sector number, sampled when a request is accepted
img_size  in  32  image size in bytes; sampled at request accept
sd_ack  out  1  high from accept+1 through the last word strobe
sd_buff_wr  out  1  one-cycle strobe per word
sd_buff_addr  out  8  word index within sector
sd_buff_dout  out  16  word data
mem_rd  out  1  one-cycle memory read strobe
mem_addr  out  LBA_W+8  word address = {lba, word index}
mem_rdata  in  16  memory data, valid exactly MEM_LATENCY cycles after mem_rd
busy  out  1  high in any state other than IDLE
sectors_served  out  16  count of completed sectors; wraps 0xFFFF->0

Behaviour:
- Reset values: all outputs 0. State IDLE, word index 0, latency counter 0.
- Reset mid-transfer aborts immediately: sd_ack drops next edge, and any in-flight memory data is discarded.
- IDLE: when sd_rd=1, latch sd_lba and img_size, clear the word index, and go to FETCH. sd_ack=1 from the next cycle.
- FETCH: pulse mem_rd for one cycle with mem_addr={lba, idx}, then go to WAIT.
- WAIT: count MEM_LATENCY cycles. On the cycle mem_rdata is valid, capture it and go to WRITE.
- WRITE: for one cycle drive sd_buff_wr=1, sd_buff_addr=idx, sd_buff_dout=captured word.
  - If idx == SECTOR_WORDS-1: increment sectors_served and go to DONE.
  - Otherwise: idx+1 and go to FETCH.
- Per-word cost: MEM_LATENCY+2 cycles. Strobes are never back-to-back.
- DONE: sd_ack=0 and go to RELEASE.
- RELEASE: wait for sd_rd=0, then go to IDLE. A request still held high after completion is never served twice. sd_rd rising in the same cycle it is seen low is accepted on the following IDLE cycle.
- sd_rd dropping mid-transfer is ignored; the sector always completes.
- sd_lba/img_size changes after accept have no effect until the next accept.
- Memory address arithmetic: concatenation only, no overflow handling. LBA 2^LBA_W-1 is legal.
- Byte offset of a word = lba*512 + idx*2, computed at 32 bits and used for tail comparison only.

Optional Feature:
Macro: MSU_SD_TAIL_ZERO_EN.
- Defined: in FETCH, if the word's byte offset >= latched img_size, mem_rd is not pulsed, WAIT is skipped, and WRITE drives data 0x0000. Tail words cost 2 cycles each. The requester sees a full sector with a zeroed tail.
- Undefined: every word is read from memory regardless of img_size. img_size is latched but unused.

Test Plan:
1. Default params, memory word = address[15:0], sd_rd held high with sd_lba=3 → sd_ack rises 1 cycle after accept. 256 strobes, addr 0..255, dout = 0x0300+idx. Strobe spacing 4 cycles. sd_ack falls the cycle after strobe 255. sectors_served=1.
2. sd_rd held high for 2000 cycles after completion → exactly one sector served. busy stays high in RELEASE. sd_rd low then high with lba=4 → second sector served, sectors_served=2.
3. Reset asserted at word 100 → next cycle sd_ack=0, sd_buff_wr=0, busy=0. No further strobes. New request afterwards serves a full 256 words from idx 0.
4. sd_lba changed to 9 and sd_rd dropped at word 10 of an lba=5 transfer → all 256 words carry lba 5 data.
5. MSU_SD_TAIL_ZERO_EN defined, img_size=2048+100, lba=4 → words 0..49 come from memory, words 50..255 are 0x0000 with no mem_rd and 2-cycle spacing. Same run undefined → all 256 words read from memory.
6. MEM_LATENCY=1, SECTOR_WORDS=64 → 64 strobes at 3-cycle spacing, sd_buff_addr 0..63, total sd_ack high time 192 cycles.
